// File: rtl/data_mux_module.sv
// Round-robin 3-stream data multiplexer with clk-count, per-symbol and
// N-symbol switching modes; symbol_clk synchronised into clk domain.
//
// Ports:
//   clk, rst            clock and async active-high reset
//   symbol_clk          async symbol strobe (rising edge = one symbol)
//   switch_clk_cycles   dwell length N (0 behaves as 1)
//   DS1, DS2, DS3       input streams
//   mode                00 idle, 01 clk count, 10 per symbol, 11 N symbols
//   output_data         registered selected stream
module data_mux_module #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              symbol_clk,
  input  logic [CNT_W-1:0]  switch_clk_cycles,
  input  logic [DATA_W-1:0] DS1,
  input  logic [DATA_W-1:0] DS2,
  input  logic [DATA_W-1:0] DS3,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] output_data
);

  typedef enum logic [1:0] {
    SEL_DS1 = 2'b00,
    SEL_DS2 = 2'b01,
    SEL_DS3 = 2'b10,
    SEL_BAD = 2'b11
  } sel_e;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_CLK  = 2'b01;
  localparam logic [1:0] M_SYM  = 2'b10;
  localparam logic [1:0] M_NSYM = 2'b11;

  sel_e              sel, sel_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        mode_q;
  logic              s1, s2, s3;
  logic              sym_tick;
  logic [CNT_W-1:0]  n_m1;
  logic              dwell_done;
  logic              adv;
  logic [DATA_W-1:0] data_n;

  function automatic sel_e rr_next(input sel_e s);
    unique case (s)
      SEL_DS1: rr_next = SEL_DS2;
      SEL_DS2: rr_next = SEL_DS3;
      default: rr_next = SEL_DS1;
    endcase
  endfunction

  assign sym_tick = s2 & ~s3;

  // N-1 with N clamped to at least 1; >= lets a shrunk N
  // take effect on the very next cycle.
  assign n_m1 = (switch_clk_cycles == '0) ? '0
              : switch_clk_cycles - CNT_W'(1);
  assign dwell_done = (cnt >= n_m1);

  always_comb begin
    sel_n = sel;
    cnt_n = cnt;
    adv   = 1'b0;
    if (mode != mode_q) begin
      sel_n = SEL_DS1;
      cnt_n = '0;
    end else begin
      unique case (1'b1)
        (mode == M_IDLE): begin
          cnt_n = '0;
        end
        (mode == M_CLK): begin
          if (dwell_done) begin
            cnt_n = '0;
            adv   = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        (mode == M_SYM): begin
          cnt_n = '0;
          adv   = sym_tick;
        end
        (mode == M_NSYM): begin
          if (sym_tick) begin
            if (dwell_done) begin
              cnt_n = '0;
              adv   = 1'b1;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt_n = '0;
        end
      endcase
      if (mode == M_IDLE) begin
        sel_n = SEL_DS1;
      end else if (adv) begin
        sel_n = rr_next(sel);
      end else if (sel == SEL_BAD) begin
        sel_n = SEL_DS1;
      end
    end
  end

  always_comb begin
    data_n = '0;
    if (mode != M_IDLE) begin
      unique case (sel_n)
        SEL_DS1: data_n = DS1;
        SEL_DS2: data_n = DS2;
        SEL_DS3: data_n = DS3;
        default: data_n = DS1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      mode_q      <= M_IDLE;
      sel         <= SEL_DS1;
      cnt         <= '0;
      output_data <= '0;
    end else begin
      s1          <= symbol_clk;
      s2          <= s1;
      s3          <= s2;
      mode_q      <= mode;
      sel         <= sel_n;
      cnt         <= cnt_n;
      output_data <= data_n;
    end
  end

endmodule

// File: tb/tb_data_mux_module.sv
// Directed-vector bench for data_mux_module.
// Inputs change on negedge; output_data is checked on negedge.
module tb_data_mux_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       symbol_clk;
  logic [2:0] switch_clk_cycles;
  logic [7:0] DS1, DS2, DS3;
  logic [1:0] mode;
  logic [7:0] output_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] strm [3] = '{8'h0F, 8'hCC, 8'h55};

  logic [1:0] tm [24] = '{
    2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
    2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
    2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  logic ts [24] = '{
    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] tw [24] = '{
    3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5,
    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
    3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
  logic [7:0] te [24] = '{
    8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
    8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
    8'h0F, 8'hCC, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hCC};

  data_mux_module #(.DATA_W(8), .CNT_W(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .symbol_clk        (symbol_clk),
    .switch_clk_cycles (switch_clk_cycles),
    .DS1               (DS1),
    .DS2               (DS2),
    .DS3               (DS3),
    .mode              (mode),
    .output_data       (output_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    vectors++;
    assert (output_data === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, output_data, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    symbol_clk = 1'b0;
    switch_clk_cycles = 3'd5;
    mode = 2'b00;
    DS1 = 8'h11; DS2 = 8'h22; DS3 = 8'h33;

    // reset with inputs moving
    step();
    DS1 = 8'hEE; DS2 = 8'hDD; mode = 2'b01; symbol_clk = 1'b1;
    step();
    chk("reset", 8'h00);

    // release in idle
    mode = 2'b00; symbol_clk = 1'b0;
    DS1 = 8'h0F; DS2 = 8'hCC; DS3 = 8'h55;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle", 8'h00);
    end

    // mode 01, N=5
    mode = 2'b01;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("clk_n5", strm[(i / 5) % 3]);
    end

    // N=0 behaves as 1
    switch_clk_cycles = 3'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("clk_n0", strm[(i + 1) % 3]);
    end

    // mode 10, symbol period 12 clks
    switch_clk_cycles = 3'd5;
    mode = 2'b10;
    step();
    chk("sym_modechg", 8'h0F);
    for (int j = 1; j <= 48; j++) begin
      symbol_clk = ((j - 1) % 12) < 6;
      step();
      chk("sym", strm[(j >= 3) ? (((j - 3) / 12 + 1) % 3) : 0]);
    end

    // mode 11, N=2
    mode = 2'b11;
    switch_clk_cycles = 3'd2;
    for (int j = 0; j < 64; j++) begin
      symbol_clk = (j % 12) < 6;
      step();
      chk("nsym", strm[(j >= 14) ? (((j - 14) / 24 + 1) % 3) : 0]);
    end

    // mode switching mid-dwell, coincident tick
    for (int i = 0; i < 24; i++) begin
      mode = tm[i];
      symbol_clk = ts[i];
      switch_clk_cycles = tw[i];
      step();
      chk($sformatf("modesw%0d", i), te[i]);
    end

    // live data change on selected stream
    DS2 = 8'hA5;
    step();
    chk("live0", 8'hA5);
    step();
    chk("live1", 8'hA5);

    // asynchronous reset mid-dwell
    #2;
    rst = 1'b1;
    DS1 = 8'hFF;
    #1;
    chk("rst_async", 8'h00);
    step();
    chk("rst_hold", 8'h00);
    DS1 = 8'h0F;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_restart", (i < 5) ? 8'h0F : 8'hA5);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mux_module.md
Name: data_mux_module

Overview:
- Three-input, 8-bit data-stream multiplexer for the transmit datapath.
- Selects one of DS1/DS2/DS3 in round-robin order and drives it onto a registered output.
- Depending on mode, the selection advances on a fixed count of clk cycles, on each symbol_clk rising edge, or after a programmable number of symbol_clk edges.
- Everything runs in the single clk domain; symbol_clk is treated as an asynchronous strobe and synchronised internally.

Parameters:
- DATA_W, 8, width of DS1/DS2/DS3 and output_data.
- CNT_W, 3, width of switch_clk_cycles and of the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- symbol_clk  input  1  symbol-rate strobe, asynchronous to clk; sampled and synchronised internally.
- switch_clk_cycles  input  CNT_W  dwell length N. A value of 0 is treated as 1.
- DS1  input  DATA_W  stream 1.
- DS2  input  DATA_W  stream 2.
- DS3  input  DATA_W  stream 3.
- mode  input  2  00 idle, 01 clk-count switching, 10 per-symbol switching, 11 N-symbol switching.
- output_data  output  DATA_W  registered multiplexed data.

Behaviour:
- Reset (async, rst=1) clears all state:
  - output_data = 0.
  - sel = DS1.
  - dwell counter cnt = 0.
  - symbol synchroniser flops = 0.
  - registered mode mode_q = 00.
- Symbol tick generation:
  - symbol_clk passes through two flops (s1, s2), then a history flop s3.
  - sym_tick = s2 & ~s3, high for exactly one clk cycle per symbol_clk rising edge.
  - Let the first clk edge that samples symbol_clk high be edge k. sym_tick is high between edges k+1 and k+2.
  - Because the flops reset to 0, symbol_clk held high through reset release produces one tick.
- Round-robin order: DS1 -> DS2 -> DS3 -> DS1. sel is a 2-bit state; the encoding 11 is illegal and recovers to DS1 on the next clk.
- Let N = max(switch_clk_cycles, 1). N is sampled every cycle, so a change takes effect at the next comparison.
- Mode 01 (clk-count switching):
  - cnt increments every clk.
  - When cnt == N-1: cnt <= 0 and sel advances.
  - Each stream is therefore held for exactly N clk cycles. If N decreases below cnt+1, the advance happens on the next cycle and cnt clears.
- Mode 10 (per-symbol switching):
  - sel advances on every clk edge where sym_tick = 1.
  - cnt is held at 0.
- Mode 11 (N-symbol switching):
  - cnt increments only when sym_tick = 1.
  - When sym_tick = 1 and cnt == N-1: cnt <= 0 and sel advances.
- Mode 00 (idle): output_data <= 0; sel and cnt are held at DS1/0.
- Mode change:
  - On any clk edge where mode != mode_q: sel <= DS1, cnt <= 0, and the pending advance/tick for that cycle is discarded.
  - mode_q <= mode every cycle.
- Output register:
  - output_data <= stream selected by the next-state sel, or 0 in mode 00.
  - A selection change is visible on output_data at the same edge sel updates.
  - A DSx data change propagates with 1 clk latency.
  - After a mode change, DS1 appears on output_data at that edge, except mode 00, which gives 0.
- Simultaneous events: mode change has priority over advance. Reset has priority over everything.
- No handshake: output is valid every cycle after reset.

Test Plan:
- Reset: rst=1 with inputs toggling -> output_data=0 immediately, without waiting for a clk edge. Release with mode=00 -> output stays 0x00.
- Mode 01, N=5, DS1=0x0F, DS2=0xCC, DS3=0x55:
  - -> output_data is 0x0F for 5 cycles, then 0xCC for 5 cycles, then 0x55 for 5 cycles, then 0x0F again.
  - Repeat with N=0 -> the stream changes every clk.
- Mode 10, symbol_clk period 12 clk periods, clk period 1 unit (same stream values):
  - -> output advances one stream per symbol_clk rising edge, 2 clk edges after the sampling edge.
  - The stream is held 12 clk cycles and cycles 0x0F, 0xCC, 0x55.
- Mode 11, N=2, same symbol_clk -> each stream is held for 2 symbol periods (24 clk cycles).
- Mode switching 01 -> 10 -> 11 mid-dwell, e.g. at cnt=3:
  - -> output_data = 0x0F on the edge mode changes; cnt restarts.
  - A symbol tick coincident with the mode change does not advance sel.
- Live data and reset mid-run:
  - Change DS2 to 0xA5 while DS2 is selected -> output shows 0xA5 one clk later.
  - Assert rst mid-dwell -> output 0, restart from DS1.
